// File: rtl/alu_ctrl_stage_if.sv
// alu_ctrl_stage_if -- handshake and decoded-field bundle for alu_ctrl_stage.
//
// Optional feature macro: ALU_CTRL_ILLEGAL_COUNT_EN (adds illegal_cnt).
//
// Signals:
//   in_valid / in_ready / instr / flush      instruction side (from ID)
//   out_valid / out_ready                    decoded side handshake (to EX)
//   alu_op, sa, use_imm, imm_ext, illegal    decoded fields
//   illegal_cnt                              saturating illegal-instruction count
// Modports:
//   slave  : the decode stage itself
//   master : the surrounding pipeline (ID producer + EX consumer)
interface alu_ctrl_stage_if #(
    parameter int WORD_WIDTH = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [31:0]           instr;
    logic                  flush;
    logic                  out_valid;
    logic                  out_ready;
    logic [4:0]            alu_op;
    logic [4:0]            sa;
    logic                  use_imm;
    logic [WORD_WIDTH-1:0] imm_ext;
    logic                  illegal;
`ifdef ALU_CTRL_ILLEGAL_COUNT_EN
    logic [15:0]           illegal_cnt;
`endif

    modport slave (
        input  in_valid, instr, flush, out_ready,
        output in_ready, out_valid, alu_op, sa, use_imm, imm_ext, illegal
`ifdef ALU_CTRL_ILLEGAL_COUNT_EN
        , output illegal_cnt
`endif
    );

    modport master (
        output in_valid, instr, flush, out_ready,
        input  in_ready, out_valid, alu_op, sa, use_imm, imm_ext, illegal
`ifdef ALU_CTRL_ILLEGAL_COUNT_EN
        , input illegal_cnt
`endif
    );
endinterface

// File: rtl/alu_ctrl_stage.sv
// alu_ctrl_stage -- single-entry registered MIPS ALU-control decode stage.
//
// Optional feature macro: ALU_CTRL_ILLEGAL_COUNT_EN
//   defined   -> 16-bit saturating count of accepted illegal instructions
//   undefined -> no counter, no illegal_cnt signal
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high
//   bus    alu_ctrl_stage_if.slave (instruction in, decoded fields out)
module alu_ctrl_stage #(
    parameter int WORD_WIDTH = 32
) (
    input  logic            clk,
    input  logic            reset,
    alu_ctrl_stage_if.slave bus
);
    logic [5:0]            op;
    logic [5:0]            funct;
    logic [4:0]            dec_alu_op;
    logic                  dec_use_imm;
    logic                  dec_illegal;
    logic [WORD_WIDTH-1:0] dec_imm_ext;
    logic [WORD_WIDTH-1:0] imm_sext;
    logic [WORD_WIDTH-1:0] imm_zext;
    logic                  in_ready;
    logic                  accept;

    logic                  valid_q,   valid_d;
    logic [4:0]            alu_op_q,  alu_op_d;
    logic [4:0]            sa_q,      sa_d;
    logic                  use_imm_q, use_imm_d;
    logic [WORD_WIDTH-1:0] imm_ext_q, imm_ext_d;
    logic                  illegal_q, illegal_d;

    // Register fields rs/rt/rd are irrelevant to ALU control.
    logic unused_instr_bits;
    assign unused_instr_bits = ^bus.instr[25:11];

    assign op       = bus.instr[31:26];
    assign funct    = bus.instr[5:0];
    assign imm_sext = {{(WORD_WIDTH-16){bus.instr[15]}}, bus.instr[15:0]};
    assign imm_zext = {{(WORD_WIDTH-16){1'b0}}, bus.instr[15:0]};

    always_comb begin
        dec_alu_op  = 5'b11111;
        dec_use_imm = 1'b0;
        dec_illegal = 1'b0;
        dec_imm_ext = imm_sext;
        if (op == 6'b000000) begin
            dec_imm_ext = '0;
            case (funct)
                6'b100100: dec_alu_op = 5'b00000;
                6'b100101: dec_alu_op = 5'b00001;
                6'b100000: dec_alu_op = 5'b00010;
                6'b100110: dec_alu_op = 5'b00011;
                6'b000000: dec_alu_op = 5'b00100;
                6'b000010: dec_alu_op = 5'b00101;
                6'b100010: dec_alu_op = 5'b00110;
                6'b101010: dec_alu_op = 5'b00111;
                6'b000011: dec_alu_op = 5'b01000;
                6'b000110: dec_alu_op = 5'b01001;
                6'b000111: dec_alu_op = 5'b01010;
                6'b000100: dec_alu_op = 5'b01011;
                6'b100111: dec_alu_op = 5'b01100;
                6'b100001: dec_alu_op = 5'b01101;
                6'b100011: dec_alu_op = 5'b01110;
                6'b101011: dec_alu_op = 5'b01111;
                default:   dec_illegal = 1'b1;
            endcase
        end else begin
            dec_use_imm = 1'b1;
            case (op)
                6'b001000: dec_alu_op = 5'b10000;
                6'b001001: dec_alu_op = 5'b10001;
                6'b001100: begin dec_alu_op = 5'b10010; dec_imm_ext = imm_zext; end
                6'b001101: begin dec_alu_op = 5'b10011; dec_imm_ext = imm_zext; end
                6'b001110: begin dec_alu_op = 5'b10100; dec_imm_ext = imm_zext; end
                6'b001010: dec_alu_op = 5'b10101;
                6'b001011: dec_alu_op = 5'b10110;
                6'b001111: begin dec_alu_op = 5'b10111; dec_imm_ext = imm_zext; end
                6'b100011,
                6'b101011: dec_alu_op = 5'b00010;
                // Branches compare two registers, so B comes from the register file.
                6'b000100,
                6'b000101: begin dec_alu_op = 5'b00110; dec_use_imm = 1'b0; end
                default: begin
                    dec_use_imm = 1'b0;
                    dec_illegal = 1'b1;
                end
            endcase
        end
    end

    assign in_ready = !valid_q || bus.out_ready;
    assign accept   = bus.in_valid && in_ready && !bus.flush;

    always_comb begin
        valid_d   = valid_q;
        alu_op_d  = alu_op_q;
        sa_d      = sa_q;
        use_imm_d = use_imm_q;
        imm_ext_d = imm_ext_q;
        illegal_d = illegal_q;
        if (bus.flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            // Covers both an empty stage and pop-and-replace in one edge.
            valid_d   = 1'b1;
            alu_op_d  = dec_alu_op;
            sa_d      = bus.instr[10:6];
            use_imm_d = dec_use_imm;
            imm_ext_d = dec_imm_ext;
            illegal_d = dec_illegal;
        end else if (valid_q && bus.out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q   <= 1'b0;
            alu_op_q  <= '0;
            sa_q      <= '0;
            use_imm_q <= 1'b0;
            imm_ext_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            alu_op_q  <= alu_op_d;
            sa_q      <= sa_d;
            use_imm_q <= use_imm_d;
            imm_ext_q <= imm_ext_d;
            illegal_q <= illegal_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = valid_q;
    assign bus.alu_op    = alu_op_q;
    assign bus.sa        = sa_q;
    assign bus.use_imm   = use_imm_q;
    assign bus.imm_ext   = imm_ext_q;
    assign bus.illegal   = illegal_q;

`ifdef ALU_CTRL_ILLEGAL_COUNT_EN
    logic [15:0] illegal_cnt_q, illegal_cnt_d;

    always_comb begin
        illegal_cnt_d = illegal_cnt_q;
        if (accept && dec_illegal && (illegal_cnt_q != 16'hFFFF)) begin
            illegal_cnt_d = illegal_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            illegal_cnt_q <= '0;
        end else begin
            illegal_cnt_q <= illegal_cnt_d;
        end
    end

    assign bus.illegal_cnt = illegal_cnt_q;
`endif
endmodule

// File: tb/tb_alu_ctrl_stage.sv
module tb_alu_ctrl_stage;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_ctrl_stage_if #(.WORD_WIDTH(32)) bus ();
    alu_ctrl_stage #(.WORD_WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        logic [4:0]  alu_op;
        logic [4:0]  sa;
        logic        use_imm;
        logic [31:0] imm;
        logic        illegal;
    } fields_t;

    // R-type funct codes listed in alu_op order 0..15.
    logic [5:0] rfunct [16] = '{6'h24, 6'h25, 6'h20, 6'h26, 6'h00, 6'h02, 6'h22, 6'h2A,
                                6'h03, 6'h06, 6'h07, 6'h04, 6'h27, 6'h21, 6'h23, 6'h2B};
    // Immediate-ALU opcodes listed in alu_op order 16..23.
    logic [5:0] iops [8] = '{6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h0A, 6'h0B, 6'h0F};

    int          n_cmp = 0;
    int          n_bad = 0;
    logic        m_valid;
    fields_t     m_f;
    int          m_cnt;

    function automatic fields_t ref_decode(logic [31:0] w);
        fields_t f;
        f.sa      = w[10:6];
        f.alu_op  = 5'd31;
        f.use_imm = 1'b0;
        f.imm     = 32'd0;
        f.illegal = 1'b1;
        if (w[31:26] == 6'd0) begin
            for (int i = 0; i < 16; i++)
                if (rfunct[i] == w[5:0]) begin f.alu_op = 5'(i); f.illegal = 1'b0; end
        end else begin
            f.imm = {{16{w[15]}}, w[15:0]};
            for (int i = 0; i < 8; i++)
                if (iops[i] == w[31:26]) begin
                    f.alu_op = 5'(16 + i); f.use_imm = 1'b1; f.illegal = 1'b0;
                end
            if (w[31:26] inside {6'h0C, 6'h0D, 6'h0E, 6'h0F}) f.imm = {16'd0, w[15:0]};
            if (w[31:26] inside {6'h23, 6'h2B}) begin
                f.alu_op = 5'd2; f.use_imm = 1'b1; f.illegal = 1'b0;
            end
            if (w[31:26] inside {6'h04, 6'h05}) begin
                f.alu_op = 5'd6; f.illegal = 1'b0;
            end
        end
        return f;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_f     = '{alu_op: 5'd0, sa: 5'd0, use_imm: 1'b0, imm: 32'd0, illegal: 1'b0};
        m_cnt   = 0;
    endtask

    task automatic check_out(string tag);
        chk({tag, ".out_valid"}, 64'(bus.out_valid), 64'(m_valid));
        if (m_valid) begin
            chk({tag, ".alu_op"},  64'(bus.alu_op),  64'(m_f.alu_op));
            chk({tag, ".sa"},      64'(bus.sa),      64'(m_f.sa));
            chk({tag, ".use_imm"}, 64'(bus.use_imm), 64'(m_f.use_imm));
            chk({tag, ".imm_ext"}, 64'(bus.imm_ext), 64'(m_f.imm));
            chk({tag, ".illegal"}, 64'(bus.illegal), 64'(m_f.illegal));
        end
`ifdef ALU_CTRL_ILLEGAL_COUNT_EN
        chk({tag, ".illegal_cnt"}, 64'(bus.illegal_cnt), 64'(m_cnt));
`endif
    endtask

    task automatic check_zero(string tag);
        chk({tag, ".out_valid"}, 64'(bus.out_valid), 64'd0);
        chk({tag, ".in_ready"},  64'(bus.in_ready),  64'd1);
        chk({tag, ".fields"},
            64'({bus.alu_op, bus.sa, bus.use_imm, bus.illegal}), 64'd0);
        chk({tag, ".imm_ext"}, 64'(bus.imm_ext), 64'd0);
`ifdef ALU_CTRL_ILLEGAL_COUNT_EN
        chk({tag, ".illegal_cnt"}, 64'(bus.illegal_cnt), 64'd0);
`endif
    endtask

    // One clock: check in_ready mid-cycle, advance the model on the edge,
    // then optionally check registered outputs 1 ns later.
    task automatic step(string tag, bit do_chk = 1'b1);
        logic rdy, acc;
        #1;
        rdy = !m_valid || bus.out_ready;
        if (do_chk) chk({tag, ".in_ready"}, 64'(bus.in_ready), 64'(rdy));
        acc = bus.in_valid && rdy && !bus.flush;
        @(posedge clk);
        if (bus.flush) m_valid = 1'b0;
        else if (acc) begin
            m_valid = 1'b1;
            m_f     = ref_decode(bus.instr);
            if (m_f.illegal && m_cnt < 16'hFFFF) m_cnt++;
        end else if (m_valid && bus.out_ready) m_valid = 1'b0;
        #1;
        if (do_chk) check_out(tag);
    endtask

    task automatic drive(logic v, logic [31:0] w, logic ordy, logic fl);
        bus.in_valid  = v;
        bus.instr     = w;
        bus.out_ready = ordy;
        bus.flush     = fl;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int          k;
        w = $urandom;
        k = $urandom_range(0, 9);
        if (k < 4) begin
            w[31:26] = 6'd0;
            w[5:0]   = rfunct[$urandom_range(0, 15)];
        end else if (k < 7) w[31:26] = iops[$urandom_range(0, 7)];
        else if (k == 7) w[31:26] = ($urandom_range(0, 1) != 0) ? 6'h23 : 6'h04;
        else if (k == 8) w[31:26] = 6'd0;
        return w;
    endfunction

    initial begin
        reset = 1'b1;
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        model_reset();
        #2;
        check_zero("reset_hold");
        @(posedge clk); #1;
        check_zero("reset_edge");
        reset = 1'b0;

        drive(1'b1, 32'h00851020, 1'b1, 1'b0);
        step("add");
        chk("add.alu_op_const", 64'(bus.alu_op), 64'b00010);
        chk("add.use_imm_const", 64'(bus.use_imm), 64'd0);

        drive(1'b1, 32'h2084FFFF, 1'b1, 1'b0);
        step("addi");
        chk("addi.alu_op_const", 64'(bus.alu_op), 64'b10000);
        chk("addi.imm_const", 64'(bus.imm_ext), 64'hFFFFFFFF);

        drive(1'b1, 32'h3484FFFF, 1'b1, 1'b0);
        step("ori");
        chk("ori.alu_op_const", 64'(bus.alu_op), 64'b10011);
        chk("ori.imm_const", 64'(bus.imm_ext), 64'h0000FFFF);

        drive(1'b1, 32'h00A62022, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step("stall");
            chk("stall.in_ready", 64'(bus.in_ready), 64'd0);
            chk("stall.alu_op_held", 64'(bus.alu_op), 64'b10011);
        end
        bus.out_ready = 1'b1;
        step("pop_accept");
        chk("pop_accept.alu_op_const", 64'(bus.alu_op), 64'b00110);

        drive(1'b1, 32'h2084FFFF, 1'b1, 1'b1);
        step("flush");
        chk("flush.out_valid_const", 64'(bus.out_valid), 64'd0);

        drive(1'b1, 32'hFC000000, 1'b1, 1'b0);
        step("illegal");
        chk("illegal.alu_op_const", 64'(bus.alu_op), 64'b11111);
        chk("illegal.flag_const", 64'(bus.illegal), 64'd1);

        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), rand_instr(),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 9) == 0));
            step("rand");
        end

        drive(1'b1, 32'h00851020, 1'b0, 1'b0);
        step("pre_reset");
        step("pre_reset2");
        reset = 1'b1;
        #1;
        model_reset();
        check_zero("mid_reset");
        @(posedge clk); #1;
        reset = 1'b0;
        drive(1'b1, 32'h2084FFFF, 1'b1, 1'b0);
        step("post_reset");
        chk("post_reset.alu_op_const", 64'(bus.alu_op), 64'b10000);

`ifdef ALU_CTRL_ILLEGAL_COUNT_EN
        drive(1'b1, 32'hFC000000, 1'b1, 1'b1);
        step("cnt_flush_blocked");
        chk("cnt_flush_blocked.const", 64'(bus.illegal_cnt), 64'd0);
        for (int i = 0; i < 32'h10000; i++) begin
            drive(1'b1, 32'hFC000000, 1'b1, 1'b0);
            step("cnt_fill", 1'b0);
        end
        #1;
        chk("cnt_sat.const", 64'(bus.illegal_cnt), 64'hFFFF);
        step("cnt_after_sat");
        chk("cnt_after_sat.const", 64'(bus.illegal_cnt), 64'hFFFF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
